// File: rtl/aec_sched_if.sv
`timescale 1ns/1ps
// Request, engine and response signal bundle for aec_sched.
// The scheduler attaches through slave; the host/engine side attaches through master.
interface aec_sched_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 3
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        aec_ascii;
    logic              aec_ready;
    logic              aec_valid;
    logic [6:0]        aec_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [6:0]        rsp_result;
    logic              rsp_err;
    logic              busy;

    modport slave (
        input  req_valid, req_data, aec_valid, aec_result, rsp_ready,
        output req_ready, aec_ascii, aec_ready, rsp_valid, rsp_id, rsp_result, rsp_err, busy
    );

    modport master (
        output req_valid, req_data, aec_valid, aec_result, rsp_ready,
        input  req_ready, aec_ascii, aec_ready, rsp_valid, rsp_id, rsp_result, rsp_err, busy
    );
endinterface

// File: rtl/aec_sched.sv
`timescale 1ns/1ps
// Round-robin share of one AEC engine; optional WAIT timeout under AEC_SCHED_TIMEOUT_EN.
// Latency: 2 + (len+1) capture + (len+1) issue + engine latency + 1 response cycles.
// Backpressure: requester gaps stall capture; response held until rsp_ready.
module aec_sched #(
    parameter int NREQ   = 2,
    parameter int IDW    = 3,
    parameter int MAXLEN = 15
`ifdef AEC_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input logic        clk,
    input logic        rst_n,
    aec_sched_if.slave bus
);
    localparam int         LW = $clog2(MAXLEN + 1);
    localparam logic [7:0] EQ = 8'h3D;

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_CAPTURE, S_DRAIN, S_ISSUE, S_WAIT, S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [LW-1:0]  len_q, len_d;
    logic [LW-1:0]  idx_q, idx_d;
    logic           err_q, err_d;
    logic [6:0]     result_q, result_d;
    logic [7:0]     mem_q [2**LW];
    logic           mem_we;
    logic           cur_vld;
    logic [7:0]     cur_chr;
    logic [IDW-1:0] grant;
    logic           grant_vld;

`ifdef AEC_SCHED_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Lowest offset from rr_ptr wins, so the last served requester ranks last.
    always_comb begin
        grant     = rr_ptr_q;
        grant_vld = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
                grant     = IDW'((int'(rr_ptr_q) + k) % NREQ);
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        cur_vld       = 1'b0;
        cur_chr       = 8'h00;
        bus.req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == rr_ptr_q) begin
                cur_vld          = bus.req_valid[i];
                cur_chr          = bus.req_data[8*i +: 8];
                bus.req_ready[i] = (state_q == S_CAPTURE) || (state_q == S_DRAIN);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        len_d    = len_q;
        idx_d    = idx_q;
        err_d    = err_q;
        result_d = result_q;
        mem_we   = 1'b0;
`ifdef AEC_SCHED_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: if (|bus.req_valid) state_d = S_ARB;
            S_ARB: begin
                if (grant_vld) begin
                    rr_ptr_d = grant;
                    len_d    = '0;
                    err_d    = 1'b0;
                    result_d = '0;
                    state_d  = S_CAPTURE;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_CAPTURE: begin
                if (cur_vld) begin
                    if (cur_chr == EQ) begin
                        idx_d = '0;
                        if (len_q == '0) begin
                            err_d   = 1'b1;
                            state_d = S_RESP;
                        end else begin
                            state_d = S_ISSUE;
                        end
                    end else if (len_q == LW'(MAXLEN)) begin
                        err_d   = 1'b1;
                        state_d = S_DRAIN;
                    end else begin
                        mem_we = 1'b1;
                        len_d  = len_q + 1'b1;
                    end
                end
            end
            S_DRAIN: if (cur_vld && cur_chr == EQ) state_d = S_RESP;
            S_ISSUE: begin
                if (idx_q == len_q) begin
                    state_d = S_WAIT;
`ifdef AEC_SCHED_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.aec_valid) begin
                    result_d = bus.aec_result;
                    err_d    = 1'b0;
                    state_d  = S_RESP;
                end
`ifdef AEC_SCHED_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= IDW'(NREQ - 1);
            len_q    <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
`ifdef AEC_SCHED_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            result_q <= result_d;
`ifdef AEC_SCHED_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[len_q] <= cur_chr;
    end

    assign bus.aec_ascii  = (state_q == S_ISSUE) ? ((idx_q == len_q) ? EQ : mem_q[idx_q]) : 8'h00;
    assign bus.aec_ready  = (state_q == S_ISSUE) && (idx_q == '0);
    assign bus.rsp_valid  = (state_q == S_RESP);
    assign bus.rsp_id     = (state_q == S_RESP) ? rr_ptr_q : '0;
    assign bus.rsp_result = (state_q == S_RESP) ? result_q : '0;
    assign bus.rsp_err    = (state_q == S_RESP) ? err_q : 1'b0;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_aec_sched.sv
`timescale 1ns/1ps
// Directed bench for aec_sched: expression-level scoreboard plus a latency-3 engine model.
module tb_aec_sched;
    localparam int NREQ = 2, IDW = 3, MAXLEN = 15, LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aec_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    logic       rv [NREQ];
    logic [7:0] rd [NREQ];
    logic       eng_vld;
    logic [6:0] eng_res;
    logic       rsp_rdy;
    logic       eng_mute;

    for (genvar i = 0; i < NREQ; i++) begin : g_drv
        assign bus.req_valid[i]       = rv[i];
        assign bus.req_data[8*i +: 8] = rd[i];
    end
    assign bus.aec_valid  = eng_vld;
    assign bus.aec_result = eng_res;
    assign bus.rsp_ready  = rsp_rdy;

    aec_sched #(
        .NREQ(NREQ),
        .IDW(IDW),
        .MAXLEN(MAXLEN)
`ifdef AEC_SCHED_TIMEOUT_EN
        ,
        .TIMEOUT(20)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    typedef struct { int id; int res; int err; } rsp_t;

    int         checks = 0;
    int         errors = 0;
    int         eng_tbl [string];
    rsp_t       exp_rsp [$];
    logic [7:0] exp_burst [$];
    int         ids_seen [$];
    int         ord4 [4] = '{0, 1, 0, 1};
    logic       in_burst = 1'b0;
    string      cur_burst = "";
    string      last_burst = "";
    int         last_id = -1, last_res = -1, last_err = -1;
    int         rdy_pulses = 0;
    int         cyc = 0, eq_cyc = 0, rsp_cyc = 0;
    logic       prev_rv = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\", want \"%s\"", name, act, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_req_ready"}, int'(bus.req_ready), 0);
        chk({tag, "_aec_ascii"}, int'(bus.aec_ascii), 0);
        chk({tag, "_aec_ready"}, int'(bus.aec_ready), 0);
        chk({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
        chk({tag, "_rsp_id"}, int'(bus.rsp_id), 0);
        chk({tag, "_rsp_result"}, int'(bus.rsp_result), 0);
        chk({tag, "_rsp_err"}, int'(bus.rsp_err), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    // Outcome of one expression from the rules alone: reject empty/oversized, else engine result.
    task automatic expect_expr(input int id, input string e);
        rsp_t  r;
        int    n;
        string body;
        n    = e.len() - 1;
        r.id = id;
        if (n == 0 || n > MAXLEN) begin
            r.err = 1;
            r.res = 0;
        end else begin
            body  = e.substr(0, n - 1);
            r.err = eng_mute ? 1 : 0;
            r.res = eng_mute ? 0 : (eng_tbl.exists(body) ? eng_tbl[body] : 127);
            for (int i = 0; i <= n; i++) exp_burst.push_back(e[i]);
        end
        exp_rsp.push_back(r);
    endtask

    task automatic send(input int r, input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            int n;
            rv[r] = 1'b1;
            rd[r] = s[i];
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.req_ready[r] && n < 300);
            if (!bus.req_ready[r]) begin
                chk("accept_timeout", int'(bus.req_ready[r]), 1);
                rv[r] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (gap != 0) begin
                rv[r] = 1'b0;
                rd[r] = 8'h00;
                @(posedge clk);
                #1;
            end
        end
        rv[r] = 1'b0;
        rd[r] = 8'h00;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_rsp.size() != 0 || bus.busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_rsp.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Engine model: collects the burst, answers LAT cycles after '=' from the lookup table.
    initial begin
        string      s;
        int         cd;
        logic       fire;
        logic [6:0] res;
        eng_vld = 1'b0;
        eng_res = '0;
        s = "";
        cd = 0;
        res = '0;
        forever begin
            @(negedge clk);
            fire = 1'b0;
            if (!rst_n) begin
                s  = "";
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    fire = (cd == 0) && !eng_mute;
                end
                if (bus.aec_ascii == 8'h3D) begin
                    res = eng_tbl.exists(s) ? 7'(eng_tbl[s]) : 7'd127;
                    s   = "";
                    cd  = LAT;
                end else if (bus.aec_ascii != 8'h00) begin
                    s = $sformatf("%s%c", s, bus.aec_ascii);
                end
            end
            @(posedge clk);
            #1;
            eng_vld = fire;
            eng_res = fire ? res : 7'd0;
        end
    end

    // Per-cycle compare against the scoreboard queues.
    initial begin
        logic [NREQ-1:0] rr;
        logic [7:0]      c;
        rsp_t            r;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) continue;
            rr = bus.req_ready;
            if (rr != '0) begin
                if (exp_rsp.size() == 0) chk("grant_unexpected", int'(rr), 0);
                else chk("grant", int'(rr), 1 << exp_rsp[0].id);
                chk("busy_capture", int'(bus.busy), 1);
            end
            if (in_burst || bus.aec_ascii != 8'h00) begin
                if (exp_burst.size() == 0) begin
                    chk("burst_unexpected", int'(bus.aec_ascii), 0);
                end else begin
                    c = exp_burst.pop_front();
                    chk("aec_ascii", int'(bus.aec_ascii), int'(c));
                    chk("aec_ready", int'(bus.aec_ready), in_burst ? 0 : 1);
                    if (!in_burst) cur_burst = "";
                    cur_burst = $sformatf("%s%c", cur_burst, bus.aec_ascii);
                    in_burst  = (c != 8'h3D);
                    if (!in_burst) begin
                        last_burst = cur_burst;
                        eq_cyc     = cyc;
                    end
                end
            end else begin
                chk("aec_ready_idle", int'(bus.aec_ready), 0);
            end
            if (bus.aec_ready) rdy_pulses++;
            if (bus.rsp_valid && !prev_rv) rsp_cyc = cyc;
            prev_rv = bus.rsp_valid;
            if (bus.rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    chk("rsp_unexpected", int'(bus.rsp_valid), 0);
                end else begin
                    chk("rsp_id", int'(bus.rsp_id), exp_rsp[0].id);
                    chk("rsp_result", int'(bus.rsp_result), exp_rsp[0].res);
                    chk("rsp_err", int'(bus.rsp_err), exp_rsp[0].err);
                    chk("rsp_no_grant", int'(rr), 0);
                    chk("busy_rsp", int'(bus.busy), 1);
                    if (bus.rsp_ready) begin
                        r        = exp_rsp.pop_front();
                        last_id  = int'(bus.rsp_id);
                        last_res = int'(bus.rsp_result);
                        last_err = int'(bus.rsp_err);
                        ids_seen.push_back(last_id);
                    end
                end
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, n, hv;
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1'b0;
            rd[i] = 8'h00;
        end
        rsp_rdy  = 1'b1;
        eng_mute = 1'b0;
        eng_tbl["3+4*2"]   = 11;
        eng_tbl["(a-3)*2"] = 14;
        eng_tbl["1+2"]     = 3;
        eng_tbl["9-4"]     = 5;
        eng_tbl["2*3"]     = 6;
        eng_tbl["8-1"]     = 7;

        #1 chk_rst("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back capture, gap-free burst
        p0 = rdy_pulses;
        expect_expr(0, "3+4*2=");
        send(0, "3+4*2=", 0);
        wait_done();
        chk_str("t1_burst", last_burst, "3+4*2=");
        chk("t1_ready_pulses", rdy_pulses - p0, 1);
        chk("t1_id", last_id, 0);
        chk("t1_result", last_res, 11);
        chk("t1_err", last_err, 0);

        // Gapped capture still yields gap-free burst
        expect_expr(1, "(a-3)*2=");
        send(1, "(a-3)*2=", 1);
        wait_done();
        chk_str("t2_burst", last_burst, "(a-3)*2=");
        chk("t2_id", last_id, 1);
        chk("t2_result", last_res, 14);

        // Fairness with both requesters continuously valid
        ids_seen.delete();
        expect_expr(0, "1+2=");
        expect_expr(1, "9-4=");
        expect_expr(0, "2*3=");
        expect_expr(1, "8-1=");
        fork
            begin send(0, "1+2=", 0); send(0, "2*3=", 0); end
            begin send(1, "9-4=", 0); send(1, "8-1=", 0); end
        join
        wait_done();
        chk("t3_count", ids_seen.size(), 4);
        for (int i = 0; i < 4 && i < ids_seen.size(); i++) chk("t3_order", ids_seen[i], ord4[i]);

        // Empty expression
        p0 = rdy_pulses;
        expect_expr(0, "=");
        send(0, "=", 0);
        wait_done();
        chk("t4_err", last_err, 1);
        chk("t4_result", last_res, 0);
        chk("t4_ready_pulses", rdy_pulses - p0, 0);

        // Overflow: 16 characters, all drained
        p0 = rdy_pulses;
        expect_expr(0, "0123456789012345=");
        send(0, "0123456789012345=", 0);
        wait_done();
        chk("t5_err", last_err, 1);
        chk("t5_result", last_res, 0);
        chk("t5_ready_pulses", rdy_pulses - p0, 0);

        // Exactly MAXLEN characters is accepted and issued
        expect_expr(1, "123456789012345=");
        send(1, "123456789012345=", 0);
        wait_done();
        chk_str("t6_burst", last_burst, "123456789012345=");
        chk("t6_err", last_err, 0);
        chk("t6_result", last_res, 127);

        // Response held for 10 cycles, no grant until accepted
        rsp_rdy = 1'b0;
        expect_expr(1, "9-4=");
        expect_expr(0, "2*3=");
        send(1, "9-4=", 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid && n < 200);
        fork
            send(0, "2*3=", 0);
        join_none
        hv = 0;
        for (int i = 0; i < 10; i++) begin
            hv += int'(bus.rsp_valid);
            if (i < 9) @(negedge clk);
        end
        chk("t7_hold_cycles", hv, 10);
        @(posedge clk);
        #1 rsp_rdy = 1'b1;
        wait_done();
        chk("t7_last_id", last_id, 0);
        chk("t7_last_result", last_res, 6);

        // Reset during ISSUE
        expect_expr(0, "3+4*2=");
        send(0, "3+4*2=", 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.aec_ready && n < 50);
        chk("t8_issue_seen", int'(bus.aec_ready), 1);
        #2 rst_n = 1'b0;
        #1 chk_rst("mid_issue");
        exp_rsp.delete();
        exp_burst.delete();
        in_burst = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t8_no_rsp", int'(bus.busy), 0);

        // After reset requester 0 wins first
        ids_seen.delete();
        expect_expr(0, "1+2=");
        expect_expr(1, "9-4=");
        fork
            send(0, "1+2=", 0);
            send(1, "9-4=", 0);
        join
        wait_done();
        chk("t9_count", ids_seen.size(), 2);
        if (ids_seen.size() > 0) chk("t9_first", ids_seen[0], 0);

`ifdef AEC_SCHED_TIMEOUT_EN
        // Silent engine: timeout after TIMEOUT=20 WAIT cycles
        eng_mute = 1'b1;
        expect_expr(0, "1+2=");
        send(0, "1+2=", 0);
        wait_done();
        chk("t10_err", last_err, 1);
        chk("t10_result", last_res, 0);
        chk("t10_wait_cycles", rsp_cyc - eq_cyc, 21);
        eng_mute = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
